wb_assoc_cache: RTL and testbench

WB_ASSOC_CACHE -- requirements
Module: wb_assoc_cache

---
 rtl/wb_assoc_cache.sv | 261 ++++++++++++++++++++++++++
 tb/tb_wb_assoc_cache.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_assoc_cache.sv
// rtl/wb_assoc_cache.sv - set-associative write-back, write-allocate cache with LRU replacement and flush
module wb_assoc_cache #(
    parameter int SETS      = 16,
    parameter int WAYS      = 4,
    parameter int LINEWORDS = 4,
    parameter int ADDRBITS  = 32,
    parameter int WORDBITS  = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req,
    input  logic                op,
    input  logic [ADDRBITS-1:0] addr,
    input  logic [WORDBITS-1:0] wdata,
    output logic [WORDBITS-1:0] rdata,
    output logic                ready,
    output logic                busy,
    input  logic                flush,
    output logic                flush_done,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDRBITS-1:0] mem_addr,
    output logic [WORDBITS-1:0] mem_wdata,
    input  logic [WORDBITS-1:0] mem_rdata,
    input  logic                mem_ack
);
    localparam int OFFW = $clog2(LINEWORDS);
    localparam int IDXW = $clog2(SETS);
    localparam int AGEW = $clog2(WAYS);
    localparam int TAGW = ADDRBITS - OFFW - IDXW;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_WRITEBACK = 3'd2;
    localparam logic [2:0] S_REFILL    = 3'd3;
    localparam logic [2:0] S_RESPOND   = 3'd4;
    localparam logic [2:0] S_FLUSH     = 3'd5;

    logic [2:0]          state;
    logic                r_op;
    logic [ADDRBITS-1:0] r_addr;
    logic [WORDBITS-1:0] r_wdata;
    logic [AGEW-1:0]     way_sel;
    logic [OFFW-1:0]     beat;
    logic                gap;
    logic                fl_wb;
    logic [IDXW-1:0]     fset;
    logic [AGEW-1:0]     fway;

    logic                valid [SETS][WAYS];
    logic                dirty [SETS][WAYS];
    logic [TAGW-1:0]     tags  [SETS][WAYS];
    logic [AGEW-1:0]     age   [SETS][WAYS];
    logic [WORDBITS-1:0] data  [SETS][WAYS][LINEWORDS];

    logic [OFFW-1:0] r_off;
    logic [IDXW-1:0] r_idx;
    logic [TAGW-1:0] r_tag;
    assign r_off = r_addr[OFFW-1:0];
    assign r_idx = r_addr[OFFW +: IDXW];
    assign r_tag = r_addr[ADDRBITS-1 -: TAGW];

    logic            hit;
    logic [AGEW-1:0] hit_way;
    logic            any_inv;
    logic [AGEW-1:0] inv_way;
    logic [AGEW-1:0] lru_way;
    logic [AGEW-1:0] victim;

    // Invalid ways are scanned from the top so the lowest index wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        lru_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[r_idx][w] && tags[r_idx][w] == r_tag) begin
                hit     = 1'b1;
                hit_way = AGEW'(w);
            end
            if (age[r_idx][w] == AGEW'(WAYS - 1)) begin
                lru_way = AGEW'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[r_idx][w]) begin
                any_inv = 1'b1;
                inv_way = AGEW'(w);
            end
        end
        victim = any_inv ? inv_way : lru_way;
    end

    logic beat_done;
    logic last_beat;
    assign beat_done = mem_req && mem_ack;
    assign last_beat = (beat == OFFW'(LINEWORDS - 1));

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tags[r_idx][way_sel], r_idx, beat};
                mem_wdata = data[r_idx][way_sel][beat];
            end
            S_REFILL: begin
                if (!gap) begin
                    mem_req  = 1'b1;
                    mem_addr = {r_tag, r_idx, beat};
                end
            end
            S_FLUSH: begin
                if (fl_wb) begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {tags[fset][fway], fset, beat};
                    mem_wdata = data[fset][fway][beat];
                end
            end
            default: ;
        endcase
    end

    assign ready = (state == S_RESPOND);
    assign busy  = (state != S_IDLE);
    assign rdata = (state == S_RESPOND && !r_op) ? data[r_idx][way_sel][r_off] : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            r_op       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            way_sel    <= '0;
            beat       <= '0;
            gap        <= 1'b0;
            fl_wb      <= 1'b0;
            fset       <= '0;
            fway       <= '0;
            flush_done <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    dirty[s][w] <= 1'b0;
                    tags[s][w]  <= '0;
                    age[s][w]   <= AGEW'(w);
                end
            end
        end else begin
            flush_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (flush) begin
                        state <= S_FLUSH;
                        fset  <= '0;
                        fway  <= '0;
                        fl_wb <= 1'b0;
                        beat  <= '0;
                    end else if (req) begin
                        r_op    <= op;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        state   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    beat <= '0;
                    gap  <= 1'b0;
                    if (hit) begin
                        way_sel <= hit_way;
                        state   <= S_RESPOND;
                    end else begin
                        way_sel <= victim;
                        state   <= (valid[r_idx][victim] && dirty[r_idx][victim]) ? S_WRITEBACK : S_REFILL;
                    end
                end
                S_WRITEBACK: begin
                    if (beat_done) begin
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            dirty[r_idx][way_sel] <= 1'b0;
                            gap                   <= 1'b1;
                            state                 <= S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    gap <= 1'b0;
                    if (beat_done) begin
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            valid[r_idx][way_sel] <= 1'b1;
                            dirty[r_idx][way_sel] <= 1'b0;
                            tags[r_idx][way_sel]  <= r_tag;
                            state                 <= S_RESPOND;
                        end
                    end
                end
                S_RESPOND: begin
                    if (r_op) begin
                        dirty[r_idx][way_sel] <= 1'b1;
                    end
                    for (int w = 0; w < WAYS; w++) begin
                        if (AGEW'(w) == way_sel) begin
                            age[r_idx][w] <= '0;
                        end else if (age[r_idx][w] < age[r_idx][way_sel]) begin
                            age[r_idx][w] <= age[r_idx][w] + 1'b1;
                        end
                    end
                    state <= S_IDLE;
                end
                S_FLUSH: begin
                    // A dirty line is written back first, then revisited clean and invalidated.
                    if (fl_wb) begin
                        if (beat_done) begin
                            beat <= beat + 1'b1;
                            if (last_beat) begin
                                dirty[fset][fway] <= 1'b0;
                                fl_wb             <= 1'b0;
                            end
                        end
                    end else if (valid[fset][fway] && dirty[fset][fway]) begin
                        fl_wb <= 1'b1;
                        beat  <= '0;
                    end else begin
                        valid[fset][fway] <= 1'b0;
                        age[fset][fway]   <= fway;
                        if (fway == AGEW'(WAYS - 1)) begin
                            fway <= '0;
                            if (fset == IDXW'(SETS - 1)) begin
                                fset       <= '0;
                                flush_done <= 1'b1;
                                state      <= S_IDLE;
                            end else begin
                                fset <= fset + 1'b1;
                            end
                        end else begin
                            fway <= fway + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (state == S_REFILL && beat_done) begin
            data[r_idx][way_sel][beat] <= mem_rdata;
        end
        if (state == S_RESPOND && r_op) begin
            data[r_idx][way_sel][r_off] <= r_wdata;
        end
    end
endmodule

// File: tb/tb_wb_assoc_cache.sv
// tb/tb_wb_assoc_cache.sv - randomized self-checking bench for wb_assoc_cache
module tb_wb_assoc_cache;
    localparam int SETS = 16, WAYS = 4, LW = 4, AB = 32, WB = 32;

    logic          clock, reset, req, op, flush, flush_done;
    logic [AB-1:0] addr, mem_addr;
    logic [WB-1:0] wdata, rdata, mem_wdata, mem_rdata;
    logic          ready, busy, mem_req, mem_we, mem_ack;

    wb_assoc_cache #(.SETS(SETS), .WAYS(WAYS), .LINEWORDS(LW), .ADDRBITS(AB), .WORDBITS(WB)) dut (
        .clock(clock), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .busy(busy), .flush(flush), .flush_done(flush_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct { bit we; logic [31:0] a; logic [31:0] d; } beat_t;
    beat_t obs[$];
    beat_t exp_q[$];
    logic [31:0] mem [logic [31:0]];

    int checks = 0, errors = 0;
    int rises, ready_cnt, idle_bad = 0;
    int stall_after = -1, stall_left = 0, stall_seen = 0, stall_bad = 0;
    logic [31:0] stall_addr = 0;
    bit prev_req = 0;

    // Reference model: per-line state plus a use timestamp; LRU is the oldest timestamp.
    bit          mv [SETS][WAYS];
    bit          md [SETS][WAYS];
    logic [31:0] mt [SETS][WAYS];
    logic [31:0] mdat [SETS][WAYS][LW];
    int          last_use [SETS][WAYS];
    int          tick = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a * 32'h9E3779B1 + 32'h5A5A;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                mv[s][w] = 0; md[s][w] = 0; last_use[s][w] = -w;
            end
        tick = 0;
    endtask

    // Memory responder and bus monitor, all sampled on the falling edge.
    initial begin
        mem_ack = 0; mem_rdata = 0;
        forever begin
            @(negedge clock);
            if (mem_req && stall_left > 0 && obs.size() == stall_after) begin
                if (stall_left == 5) stall_addr = mem_addr;
                mem_ack = 0;
                stall_left--;
                stall_seen++;
                if (!mem_req || mem_addr != stall_addr || !busy || ready) stall_bad++;
            end else begin
                mem_ack = ($urandom_range(0, 3) != 0);
            end
            mem_rdata = mem_req ? memval(mem_addr) : 32'h0;
            if (mem_req && !prev_req) rises++;
            prev_req = mem_req;
            if (!mem_req && (mem_we || mem_addr != 0 || mem_wdata != 0)) idle_bad++;
            if (ready) ready_cnt++;
            if (mem_req && mem_ack) begin
                obs.push_back('{we: mem_we, a: mem_addr, d: mem_we ? mem_wdata : 32'h0});
                if (mem_we) mem[mem_addr] = mem_wdata;
            end
        end
    end

    task automatic compare_traffic(input string tag);
        chk({tag, "_beats"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            chk({tag, "_we"}, obs[i].we, exp_q[i].we);
            chk({tag, "_addr"}, obs[i].a, exp_q[i].a);
            chk({tag, "_wdata"}, obs[i].d, exp_q[i].d);
        end
    endtask

    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd);
        int s, off, w, lat, nwb;
        logic [31:0] t, base, expd;
        bit h;
        s = int'(a[5:2]); off = int'(a[1:0]); t = a >> 6;
        h = 0; w = 0; nwb = 0;
        exp_q.delete();
        for (int i = 0; i < WAYS; i++) if (mv[s][i] && mt[s][i] == t) begin h = 1; w = i; end
        if (!h) begin
            w = -1;
            for (int i = WAYS - 1; i >= 0; i--) if (!mv[s][i]) w = i;
            if (w < 0) begin
                w = 0;
                for (int i = 1; i < WAYS; i++) if (last_use[s][i] < last_use[s][w]) w = i;
            end
            if (mv[s][w] && md[s][w]) begin
                nwb = 1;
                base = (mt[s][w] << 6) | (s << 2);
                for (int b = 0; b < LW; b++) exp_q.push_back('{we: 1, a: base + b, d: mdat[s][w][b]});
            end
            base = (t << 6) | (s << 2);
            for (int b = 0; b < LW; b++) begin
                exp_q.push_back('{we: 0, a: base + b, d: 32'h0});
                mdat[s][w][b] = memval(base + b);
            end
            mv[s][w] = 1; md[s][w] = 0; mt[s][w] = t;
        end
        if (wr) begin mdat[s][w][off] = wd; md[s][w] = 1; end
        last_use[s][w] = ++tick;
        expd = mdat[s][w][off];

        obs.delete(); rises = 0; ready_cnt = 0;
        @(negedge clock); req = 1; op = wr; addr = a; wdata = wd;
        @(posedge clock);
        @(negedge clock); req = 0; lat = 1;
        while (!ready && lat < 3000) begin @(negedge clock); lat++; end
        chk("ready_seen", ready, 1);
        if (!wr) chk("rdata", rdata, expd);
        if (h) begin
            chk("hit_latency", lat, 2);
            chk("hit_no_mem", obs.size(), 0);
        end else begin
            compare_traffic("miss");
            chk("burst_count", rises, 1 + nwb);
        end
        @(negedge clock);
        chk("ready_pulse", ready, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic do_flush(input bit with_req);
        int n, lat;
        exp_q.delete(); n = 0;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (mv[s][w] && md[s][w]) begin
                    n++;
                    for (int b = 0; b < LW; b++)
                        exp_q.push_back('{we: 1, a: ((mt[s][w] << 6) | (s << 2)) + b, d: mdat[s][w][b]});
                end
        obs.delete(); rises = 0; ready_cnt = 0;
        @(negedge clock); flush = 1;
        if (with_req) begin req = 1; op = 0; addr = $urandom_range(0, 1023); end
        @(posedge clock);
        @(negedge clock); flush = 0; req = 0; lat = 1;
        while (!flush_done && lat < 8000) begin @(negedge clock); lat++; end
        chk("flush_done", flush_done, 1);
        chk("flush_busy", busy, 0);
        compare_traffic("flush");
        chk("flush_bursts", rises, n);
        chk("flush_no_ready", ready_cnt, 0);
        @(negedge clock);
        chk("flush_done_pulse", flush_done, 0);
        model_clear();
    endtask

    task automatic do_reset();
        @(negedge clock); reset = 0; req = 0; flush = 0;
        repeat (2) @(negedge clock);
        model_clear();
        reset = 1;
    endtask

    initial begin
        logic [31:0] v;
        int n;
        reset = 0; req = 0; op = 0; addr = 0; wdata = 0; flush = 0;
        model_clear();
        #1;
        chk("rst_outs", {rdata, ready, busy, flush_done}, 0);
        chk("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
        repeat (3) @(negedge clock);
        reset = 1;

        access(0, 32'h100, 0);
        access(0, 32'h101, 0);
        access(1, 32'h102, 32'hDEADBEEF);
        access(0, 32'h102, 0);
        access(0, 32'h140, 0);
        access(0, 32'h180, 0);
        access(0, 32'h1C0, 0);
        access(0, 32'h200, 0);
        v = (obs.size() > 2) ? obs[2].d : 32'h0;
        chk("evict_beat2", v, 32'hDEADBEEF);

        stall_after = 2; stall_left = 5; stall_seen = 0; stall_bad = 0;
        access(0, 32'h104, 0);
        chk("stall_cycles", stall_seen, 5);
        chk("stall_stable", stall_bad, 0);
        chk("stall_addr", stall_addr, 32'h106);
        stall_after = -1;

        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 7) << 6) | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
            access($urandom_range(0, 1), v, $urandom);
            if (i % 75 == 74) do_flush($urandom_range(0, 1));
        end

        do_reset();
        access(1, 32'h300, 32'hCAFEF00D);
        do_flush(1);
        chk("one_dirty_bursts", rises, 1);
        access(0, 32'h300, 0);
        chk("post_flush_miss", obs.size(), 4);

        obs.delete();
        @(negedge clock); req = 1; op = 0; addr = 32'h3C4;
        @(negedge clock); req = 0;
        n = 0;
        while (obs.size() < 2 && n < 2000) begin @(posedge clock); n++; end
        chk("mid_burst_reached", obs.size() >= 2, 1);
        #2 reset = 0;
        #1;
        chk("rst_mid_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
        chk("rst_mid_outs", {rdata, ready, busy, flush_done}, 0);
        repeat (2) @(negedge clock);
        model_clear();
        reset = 1;
        access(0, 32'h3C4, 0);
        chk("refill_after_reset", obs.size(), 4);

        chk("idle_bus_zero", idle_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
